// File: rtl/clock_pkg.sv
// Shared definitions for the millennium clock: field select codes and set-mode timing defaults.
package clock_pkg;

  typedef enum logic [2:0] {
    SEL_RUN   = 3'b000,
    SEL_SEC   = 3'b001,
    SEL_MIN   = 3'b010,
    SEL_HOUR  = 3'b011,
    SEL_DAY   = 3'b100,
    SEL_YEAR  = 3'b101,
    SEL_MONTH = 3'b110
  } sel_e;

  localparam logic [3:0] HOLD_CYCLES  = 4'd3;
  localparam logic [5:0] IDLE_TIMEOUT = 6'd30;

  // Edit order: HOUR -> MIN -> SEC -> DAY -> MONTH -> YEAR -> back to RUN.
  function automatic sel_e next_field(input sel_e cur);
    sel_e nxt;
    case (cur)
      SEL_HOUR:  nxt = SEL_MIN;
      SEL_MIN:   nxt = SEL_SEC;
      SEL_SEC:   nxt = SEL_DAY;
      SEL_DAY:   nxt = SEL_MONTH;
      SEL_MONTH: nxt = SEL_YEAR;
      default:   nxt = SEL_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/set_mode_ctrl_if.sv
// Button levels in, field select / adjust pulses / display flags out of the set-mode controller.
interface set_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] select_item;
  logic       up;
  logic       down;
  logic       en_1;
  logic       blink;
  logic       editing;

  modport master (
    input  btn_mode, btn_next, btn_up, btn_down,
    output select_item, up, down, en_1, blink, editing
  );

  modport slave (
    output btn_mode, btn_next, btn_up, btn_down,
    input  select_item, up, down, en_1, blink, editing
  );
endinterface

// File: rtl/set_mode_ctrl_btn_repeat.sv
// Registered button edge detector with hold counter; pulses on press and auto-repeats once held long enough.
module btn_repeat
  import clock_pkg::*;
(
  input  logic clk_1Hz,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_clr,
  output logic o_pulse,
  output logic o_level
);

  logic       r_cur;
  logic       r_prev;
  logic [3:0] r_hold;

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
      r_hold <= '0;
    end else begin
      r_cur  <= i_btn;
      r_prev <= r_cur;
      // Counts every held cycle including the press cycle, then saturates.
      if (i_clr || !r_cur)
        r_hold <= '0;
      else if (r_hold != HOLD_CYCLES)
        r_hold <= r_hold + 4'd1;
    end
  end

  assign o_pulse = r_cur & (~r_prev | (r_hold == HOLD_CYCLES));
  assign o_level = r_cur;

endmodule

// File: rtl/set_mode_ctrl.sv
// Set-mode controller: sequences field editing, adjust pulses, idle timeout and blink for the clock counters.
module set_mode_ctrl
  import clock_pkg::*;
(
  input  logic              clk_1Hz,
  input  logic              rst_n,
  set_mode_ctrl_if.master   bus
);

  sel_e       r_sel;
  sel_e       w_sel_nxt;
  logic       r_up;
  logic       r_down;
  logic       r_en;
  logic       r_blink;
  logic       r_edit;
  logic [5:0] r_idle;
  logic [5:0] w_idle_nxt;
  logic       r_mode_cur;
  logic       r_mode_prev;
  logic       r_next_cur;
  logic       r_next_prev;
  logic       w_mode_press;
  logic       w_next_press;
  logic       w_edit;
  logic       w_chg;
  logic       w_clr;
  logic       w_up_nxt;
  logic       w_dn_nxt;
  logic       w_up_pulse;
  logic       w_up_lvl;
  logic       w_dn_pulse;
  logic       w_dn_lvl;

  assign w_mode_press = r_mode_cur & ~r_mode_prev;
  assign w_next_press = r_next_cur & ~r_next_prev;
  assign w_edit       = (r_sel != SEL_RUN);
  // Hold counters restart on every field change and stay idle in run.
  assign w_clr        = w_chg | ~w_edit;

  btn_repeat u_rep_up (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_up),
    .i_clr   (w_clr),
    .o_pulse (w_up_pulse),
    .o_level (w_up_lvl)
  );

  btn_repeat u_rep_dn (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .i_btn   (bus.btn_down),
    .i_clr   (w_clr),
    .o_pulse (w_dn_pulse),
    .o_level (w_dn_lvl)
  );

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n)
      r_sel <= SEL_RUN;
    else
      r_sel <= w_sel_nxt;
  end

  always_comb begin
    w_sel_nxt  = r_sel;
    w_up_nxt   = 1'b0;
    w_dn_nxt   = 1'b0;
    w_idle_nxt = '0;

    if (w_mode_press)
      w_sel_nxt = w_edit ? SEL_RUN : SEL_HOUR;
    else if (w_edit && w_next_press)
      w_sel_nxt = next_field(r_sel);
    else if (w_edit && (r_idle == IDLE_TIMEOUT))
      w_sel_nxt = SEL_RUN;

    w_chg = (w_sel_nxt != r_sel);

    if (w_edit && !w_chg && !(w_up_lvl && w_dn_lvl)) begin
      w_up_nxt = w_up_pulse;
      w_dn_nxt = w_dn_pulse;
    end

    if (w_edit && !w_chg && !w_next_press && !w_up_lvl && !w_dn_lvl)
      w_idle_nxt = r_idle + 6'd1;
  end

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_en        <= 1'b1;
      r_blink     <= 1'b1;
      r_edit      <= 1'b0;
      r_idle      <= '0;
      r_mode_cur  <= 1'b0;
      r_mode_prev <= 1'b0;
      r_next_cur  <= 1'b0;
      r_next_prev <= 1'b0;
    end else begin
      r_up        <= w_up_nxt;
      r_down      <= w_dn_nxt;
      r_en        <= (w_sel_nxt == SEL_RUN);
      r_blink     <= (w_sel_nxt == SEL_RUN) ? 1'b1 : ~r_blink;
      r_edit      <= (w_sel_nxt != SEL_RUN);
      r_idle      <= w_idle_nxt;
      r_mode_cur  <= bus.btn_mode;
      r_mode_prev <= r_mode_cur;
      r_next_cur  <= bus.btn_next;
      r_next_prev <= r_next_cur;
    end
  end

  assign bus.select_item = r_sel;
  assign bus.up          = r_up;
  assign bus.down        = r_down;
  assign bus.en_1        = r_en;
  assign bus.blink       = r_blink;
  assign bus.editing     = r_edit;

endmodule
